// File: rtl/mux_4x1_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 datapath mux.
// Captures the granted requester's word into a one-entry valid/ready stage.
module mux_4x1_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic             out_ready,
  output logic [1:0]       S,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [3:0]       beat_cnt;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             cap;
  logic             last_beat;
  logic [WIDTH-1:0] mux_data;

  always_comb begin
    unique case (S)
      2'd0: mux_data = I0;
      2'd1: mux_data = I1;
      2'd2: mux_data = I2;
      2'd3: mux_data = I3;
    endcase
  end

  // First set request at or after ptr, wrapping 3 -> 0
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign cap = (state == BUSY) && req[S]
               && (!out_valid || out_ready);
  assign ack = cap ? (4'b0001 << S) : 4'b0000;
  assign last_beat = (beat_cnt == 4'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      S         <= 2'd0;
      gnt       <= 4'b0000;
      ptr       <= 2'd0;
      beat_cnt  <= 4'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            S        <= win;
            gnt      <= 4'b0001 << win;
            beat_cnt <= 4'd0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!req[S] || (cap && last_beat)) begin
            gnt   <= 4'b0000;
            ptr   <= S + 2'd1;
            state <= IDLE;
          end
          if (cap) beat_cnt <= beat_cnt + 4'd1;
        end
      endcase
      if (cap) begin
        out_data  <= mux_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Directed bench for mux_4x1_arbiter: grant order, bursts,
// stalls, early release, async reset and pointer wrap.
module tb_mux_4x1_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] I0 = '0, I1 = '0, I2 = '0, I3 = '0;
  logic        out_ready = 1'b1;
  logic [1:0]  S;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [31:0] out_data;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  mux_4x1_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .I0        (I0),
    .I1        (I1),
    .I2        (I2),
    .I3        (I3),
    .out_ready (out_ready),
    .S         (S),
    .gnt       (gnt),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [4];
    logic [31:0] prev;
    logic        have_prev;
    int          gi;

    // reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_S", 32'(S), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_vld", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    reset_n = 1'b1;

    // single requester latency
    req = 4'b0001; I0 = 32'h2;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_S", 32'(S), 32'h0);
    check("t1_ack", 32'(ack), 32'h1);
    @(negedge clk);
    check("t1_vld", 32'(out_valid), 32'h1);
    check("t1_data", out_data, 32'h2);
    req = 4'b0000;
    @(negedge clk);
    check("t1_rel", 32'(gnt), 32'h0);
    check("t1_drain", 32'(out_valid), 32'h0);

    // full round robin with bursts
    do_reset();
    w[0] = 32'h0; w[1] = 32'h2; w[2] = 32'h4; w[3] = 32'h8;
    I0 = w[0]; I1 = w[1]; I2 = w[2]; I3 = w[3];
    req = 4'b1111;
    have_prev = 1'b0;
    prev = '0;
    for (int g = 0; g < 5; g++) begin
      gi = g % 4;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        check($sformatf("rr_gnt%0d_%0d", g, b),
              32'(gnt), 32'(4'b0001 << gi));
        check($sformatf("rr_ack%0d_%0d", g, b),
              32'(ack), 32'(4'b0001 << gi));
        if (have_prev)
          check($sformatf("rr_data%0d_%0d", g, b), out_data, prev);
        prev = w[gi];
        have_prev = 1'b1;
      end
      @(negedge clk);
      check($sformatf("rr_idle_gnt%0d", g), 32'(gnt), 32'h0);
      check($sformatf("rr_idle_ack%0d", g), 32'(ack), 32'h0);
      check($sformatf("rr_idle_data%0d", g), out_data, prev);
      check($sformatf("rr_idle_vld%0d", g), 32'(out_valid), 32'h1);
    end
    req = 4'b0000;

    // downstream stall on requester 2
    do_reset();
    I2 = 32'h4;
    req = 4'b0100;
    @(negedge clk);
    check("st_gnt", 32'(gnt), 32'h4);
    check("st_ack0", 32'(ack), 32'h4);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("st_vld%0d", c), 32'(out_valid), 32'h1);
      check($sformatf("st_data%0d", c), out_data, 32'h4);
      check($sformatf("st_gnt%0d", c), 32'(gnt), 32'h4);
      check($sformatf("st_S%0d", c), 32'(S), 32'h2);
      check($sformatf("st_ack%0d", c), 32'(ack), 32'h0);
    end
    out_ready = 1'b1;
    I2 = 32'h6;
    #1;
    check("st_resume_ack", 32'(ack), 32'h4);
    @(negedge clk);
    check("st_data2", out_data, 32'h6);
    check("st_ack2", 32'(ack), 32'h4);
    @(negedge clk);
    check("st_ack3", 32'(ack), 32'h4);
    check("st_gnt3", 32'(gnt), 32'h4);
    @(negedge clk);
    check("st_rel", 32'(gnt), 32'h0);
    check("st_rel_ack", 32'(ack), 32'h0);
    req = 4'b0000;

    // early release by requester 1
    do_reset();
    I1 = 32'h2;
    req = 4'b0010;
    @(negedge clk);
    check("er_gnt", 32'(gnt), 32'h2);
    check("er_ack0", 32'(ack), 32'h2);
    @(negedge clk);
    check("er_ack1", 32'(ack), 32'h2);
    @(negedge clk);
    req = 4'b0000;
    #1;
    check("er_ack_drop", 32'(ack), 32'h0);
    check("er_gnt_hold", 32'(gnt), 32'h2);
    @(negedge clk);
    check("er_rel", 32'(gnt), 32'h0);
    check("er_data", out_data, 32'h2);
    req = 4'b0011;
    @(negedge clk);
    check("er_next_gnt", 32'(gnt), 32'h1);
    check("er_next_S", 32'(S), 32'h0);
    req = 4'b0000;

    // async reset mid-burst
    do_reset();
    I1 = 32'hA5;
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("ar_pre_gnt", 32'(gnt), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_vld", 32'(out_valid), 32'h0);
    check("ar_S", 32'(S), 32'h0);
    check("ar_ack", 32'(ack), 32'h0);
    req = 4'b1000;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ar_gnt3", 32'(gnt), 32'h8);
    check("ar_S3", 32'(S), 32'h3);
    req = 4'b0000;

    // pointer wrap from 3 to 0
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    #1;
    check("wr_ack", 32'(ack), 32'h0);
    check("wr_gnt2", 32'(gnt), 32'h4);
    @(negedge clk);
    check("wr_rel", 32'(gnt), 32'h0);
    req = 4'b0101;
    @(negedge clk);
    check("wr_gnt", 32'(gnt), 32'h1);
    check("wr_S", 32'(S), 32'h0);
    req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_4x1_arbiter.md
Name: mux_4x1_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit 4:1 datapath mux.
- Four requesters each present a 32-bit word. The block drives the mux select, grants one requester at a time and captures that requester's word into a one-entry registered output stage with a valid/ready handshake.
- A per-grant burst limit stops any one requester from monopolising the datapath.

Parameters:
- WIDTH, 32, data width of each requester input and of out_data.
- MAX_BURST, 4, maximum beats captured per grant; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  4  req[i] high: requester i has a word on Ii.
- I0  input  WIDTH  requester 0 data.
- I1  input  WIDTH  requester 1 data.
- I2  input  WIDTH  requester 2 data.
- I3  input  WIDTH  requester 3 data.
- out_ready  input  1  downstream accepts out_data this cycle.
- S  output  2  registered mux select; index of the current or last grant.
- gnt  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  combinational one-hot; ack[i] high on the cycle Ii is captured.
- out_data  output  WIDTH  registered captured word.
- out_valid  output  1  out_data holds an unconsumed word.

Behaviour:
- Reset (reset_n low, asynchronous, any cycle including mid-burst):
  - state=IDLE, S=0, gnt=0, out_data=0, out_valid=0, ptr=0, beat_cnt=0.
  - ack=0 while reset is asserted.
  - No partial transfer survives reset.
- State IDLE:
  - If req==0: stay in IDLE.
  - Else pick the first requester with req set, scanning from ptr upward with wrap 3->0.
  - On the next edge: S<=winner, gnt<=onehot(winner), beat_cnt<=0, state<=BUSY.
  - No capture happens in IDLE.
- State BUSY:
  - cap = req[S] && (!out_valid || out_ready).
  - When cap: out_data<=I[S] (the mux output), out_valid<=1, ack[S]=1 this cycle, beat_cnt<=beat_cnt+1.
  - Release, when cap && beat_cnt==MAX_BURST-1: gnt<=0, ptr<=S+1 (mod 4), state<=IDLE.
  - Release, when req[S]==0: same actions, same cycle; no capture.
  - Otherwise stay in BUSY. Stalls (out_valid && !out_ready) hold gnt, S and beat_cnt.
- Output stage:
  - If out_ready && out_valid && !cap, then out_valid<=0.
  - Capture and downstream consumption in the same cycle: out_valid stays 1 and out_data takes the new word. Full throughput, no bubble.
- Latency and rates:
  - req rises in cycle n -> gnt valid in cycle n+1 -> first ack in cycle n+1 -> out_valid in cycle n+2.
  - Re-arbitration costs exactly one IDLE cycle between grants.
  - A sustained single requester gets at most MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness:
  - ptr always points one past the last granted index, so every active requester is served within 3 grants.
  - Requests deasserted while another requester holds the grant are simply not considered.
- S holds its value in IDLE. Only gnt indicates an active grant.
- ack is never asserted for a requester that is not granted. ack is at most one-hot.

Test Plan:
- Reset, then req=4'b0001, I0=32'h00000002, out_ready=1:
  - gnt=0001 and S=0 one cycle later; ack[0] on that same cycle.
  - out_valid=1 with out_data=32'h00000002 the cycle after that.
- req=4'b1111 held, I0..I3=0,2,4,8, out_ready=1, MAX_BURST=4:
  - Grants rotate 0,1,2,3,0.
  - Each grant gives 4 consecutive acks, then one idle cycle.
  - out_data sequence is 0x0 x4, 0x2 x4, 0x4 x4, 0x8 x4.
- Granted requester 2, out_ready=0 for 3 cycles after the first capture:
  - out_valid stays 1 with out_data=4; gnt/S/beat_cnt frozen; no ack.
  - Resumes with the second beat when out_ready=1.
- Requester 1 drops req after 2 beats (MAX_BURST=4):
  - gnt->0 on the next edge; ptr=2.
  - A following req=4'b0011 grants requester 0 (scan 2,3,0), not 1.
- reset_n pulsed low mid-burst (async, between edges):
  - gnt, out_valid, S, ack go 0 immediately.
  - After release with req=4'b1000, requester 3 is granted with ptr restarted at 0.
- ptr=3 with req=4'b0101: requester 0 is granted (wrap-around); S=0.
